// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master with a single-beat valid/ready command port.
// Shifts in_data out on mosi (MSB-first by default) while capturing miso on
// each falling sck edge, then returns the received word as a one-cycle
// out_valid pulse.
//
// Optional build macro: SPI_MASTER_LSB_FIRST_EN (LSB-first shifting; timing
// is unchanged).
//
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   in_valid/in_ready  command handshake (in_ready high only when idle)
//   in_data, in_len    right-aligned transmit word and bit count
//   in_ss              slave-select mask, bit=1 selects
//   out_valid/out_data one-cycle response pulse with right-aligned rx word
//   busy               high whenever a transfer is in progress
//   sck, ss, mosi      SPI outputs (sck idles low, ss active-low)
//   miso               SPI serial input, assumed synchronous to clock
module spi_master #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned MAX_BITS = 16,
  parameter int unsigned SS_W     = 8,
  parameter int unsigned LEN_W    = $clog2(MAX_BITS) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_BITS-1:0] in_data,
  input  logic [LEN_W-1:0]    in_len,
  input  logic [SS_W-1:0]     in_ss,
  output logic                out_valid,
  output logic [MAX_BITS-1:0] out_data,
  output logic                busy,
  output logic                sck,
  output logic [SS_W-1:0]     ss,
  output logic                mosi,
  input  logic                miso
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned MW1   = MAX_BITS + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DIV_W-1:0]    r_div;
  logic [LEN_W-1:0]    r_bitcnt;
  logic [LEN_W-1:0]    r_len;
  logic [SS_W-1:0]     r_mask;
  logic [MAX_BITS-1:0] r_tx;
  logic [MAX_BITS-1:0] r_rx;
  logic                r_out_valid;
  logic [MAX_BITS-1:0] r_out_data;

  logic                w_accept;
  logic                w_div_done;
  logic                w_last_bit;
  logic [LEN_W-1:0]    w_len_eff;
  logic [MW1-1:0]      w_len_onehot;
  logic [MAX_BITS-1:0] w_len_mask;
  logic                w_tx_bit;
  logic [MAX_BITS-1:0] w_tx_load;
  logic [MAX_BITS-1:0] w_tx_shift;
  logic [MAX_BITS-1:0] w_rx_shift;
  logic [MAX_BITS-1:0] w_rx_final;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_div_done = (r_div == '0);
  assign w_last_bit = (r_bitcnt == (r_len - LEN_W'(1)));
  assign w_len_eff  = (in_len > LEN_MAX) ? LEN_MAX : in_len;

  // Mask of the low r_len bits; the extra top bit covers r_len == MAX_BITS.
  assign w_len_onehot = MW1'(1) << r_len;
  assign w_len_mask   = MAX_BITS'(w_len_onehot - MW1'(1));

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_tx_bit   = r_tx[0];
  assign w_tx_load  = in_data;
  assign w_tx_shift = {1'b0, r_tx[MAX_BITS-1:1]};
  assign w_rx_shift = {miso, r_rx[MAX_BITS-1:1]};
  // rx filled from the top, so slide the L received bits down to bit 0.
  assign w_rx_final = (r_rx >> (LEN_MAX - r_len)) & w_len_mask;
`else
  assign w_tx_bit   = r_tx[MAX_BITS-1];
  // Put the first bit of the transfer at the top of the shifter.
  assign w_tx_load  = in_data << (LEN_MAX - w_len_eff);
  assign w_tx_shift = {r_tx[MAX_BITS-2:0], 1'b0};
  assign w_rx_shift = {r_rx[MAX_BITS-2:0], miso};
  assign w_rx_final = r_rx & w_len_mask;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; every non-idle state lasts one divider period.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        // A zero-length command completes without leaving IDLE.
        if (w_accept && (w_len_eff != '0)) w_state_next = S_SETUP;
      end
      S_SETUP: if (w_div_done) w_state_next = S_HIGH;
      S_HIGH: begin
        if (w_div_done) w_state_next = w_last_bit ? S_HOLD : S_LOW;
      end
      S_LOW:  if (w_div_done) w_state_next = S_HIGH;
      S_HOLD: if (w_div_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    sck      = 1'b0;
    ss       = '1;
    mosi     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_HIGH: begin
        sck  = 1'b1;
        ss   = ~r_mask;
        mosi = w_tx_bit;
      end
      S_SETUP, S_LOW, S_HOLD: begin
        ss   = ~r_mask;
        mosi = w_tx_bit;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
    endcase
  end

  // Divider reloads on every state entry and counts down to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_state_next != r_state) begin
      r_div <= DIV_LOAD;
    end else if (!w_div_done) begin
      r_div <= r_div - DIV_W'(1);
    end
  end

  // Shift registers, bit counter and response register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mask      <= '0;
      r_len       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_bitcnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_mask   <= in_ss;
        r_len    <= w_len_eff;
        r_tx     <= w_tx_load;
        r_rx     <= '0;
        r_bitcnt <= '0;
        if (w_len_eff == '0) begin
          r_out_valid <= 1'b1;
          r_out_data  <= '0;
        end
      end
      // Falling sck edge: sample miso; the tx shift forms the LOW entry.
      if ((r_state == S_HIGH) && w_div_done) begin
        r_rx     <= w_rx_shift;
        r_bitcnt <= r_bitcnt + LEN_W'(1);
        if (!w_last_bit) r_tx <= w_tx_shift;
      end
      if ((r_state == S_HOLD) && w_div_done) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rx_final;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: table-driven and randomized check of spi_master against a
// bit-sequence reference model (loopback, bit-reversal and random slaves).
module tb_spi_master;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [4:0]  in_len = '0;
  logic [7:0]  in_ss = '0;
  logic        in_ready, out_valid, busy, sck, mosi, miso;
  logic [15:0] out_data;
  logic [7:0]  ss;

  int total = 0;
  int bad = 0;

  // 0 = loopback, 1 = bit-reversal slave on ss[0], 2 = random miso slave
  int          mode = 0;
  logic        slave_miso = 1'b0;
  logic        sent_q[$];
  logic [15:0] rnd_seq = '0;

  assign miso = (mode == 0) ? mosi : slave_miso;

  spi_master dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .in_ss(in_ss),
    .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  initial forever #5 clock = ~clock;

  // Slave side: record mosi on each rising sck, update miso just after it.
  always @(posedge sck) begin
    int k;
    #1;
    sent_q.push_back(mosi);
    k = sent_q.size() - 1;
    if (mode == 2) begin
      slave_miso = 1'($urandom_range(0, 1));
      if (k < 16) rnd_seq[k] = slave_miso;
    end else if (mode == 1) begin
      slave_miso = (k >= 8 && k < 16) ? sent_q[15-k] : 1'b0;
    end
  end

  function automatic int eff_len(input int len);
    return (len > 16) ? 16 : len;
  endfunction

  function automatic logic [15:0] mask_of(input int l);
    logic [16:0] t;
    t = 17'(1) << l;
    return 16'(t - 17'd1);
  endfunction

  // k-th bit on the wire for an L-bit transfer of d.
  function automatic logic sent_bit(input logic [15:0] d, input int l, input int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return d[k];
`else
    return d[l-1-k];
`endif
  endfunction

  // Place a time-ordered bit sequence into a right-aligned word.
  function automatic logic [15:0] assemble(input logic [15:0] seq, input int l);
    logic [15:0] w = '0;
    for (int k = 0; k < l; k++) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
      w[k] = seq[k];
`else
      w[l-1-k] = seq[k];
`endif
    end
    return w;
  endfunction

  function automatic logic [15:0] model_out(input logic [15:0] d, input int len,
                                            input int md, input logic [15:0] rseq);
    logic [15:0] resp = '0;
    int l = eff_len(len);
    for (int k = 0; k < l; k++) begin
      if (md == 0)      resp[k] = sent_bit(d, l, k);
      else if (md == 1) resp[k] = (k >= 8) ? sent_bit(d, l, 15 - k) : 1'b0;
      else              resp[k] = rseq[k];
    end
    return assemble(resp, l);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [15:0] d, input int len, input logic [7:0] m,
                         input int md, input bit use_exp, input logic [15:0] exp_c,
                         input string tag);
    int l, cyc, lowc, viol;
    bit got;
    logic [15:0] rd, seq, exp_v;
    l = eff_len(len);
    @(negedge clock);
    check({tag, "/ready"}, 32'(in_ready), 32'd1);
    mode = md;
    sent_q.delete();
    rnd_seq = '0;
    slave_miso = 1'b0;
    in_valid = 1'b1; in_data = d; in_len = 5'(len); in_ss = m;
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_data = 16'($urandom); in_len = 5'($urandom); in_ss = 8'($urandom);
    cyc = 0; got = 0; lowc = 0; viol = 0; rd = '0;
    while (!got && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (ss !== 8'hFF) begin
        lowc++;
        if (ss !== ~m) viol++;
      end
      if (busy === in_ready) viol++;
      if (out_valid === 1'b1) begin
        got = 1;
        rd = out_data;
      end
    end
    seq = '0;
    for (int k = 0; k < sent_q.size() && k < 16; k++) seq[k] = sent_q[k];
    exp_v = use_exp ? exp_c : model_out(d, len, md, rnd_seq);
    check({tag, "/data"}, 32'(rd), 32'(exp_v));
    check({tag, "/latency"}, 32'(cyc), (l == 0) ? 32'd1 : 32'(DIV * (2 * l + 1) + 1));
    check({tag, "/ss_low"}, 32'(lowc), (l == 0) ? 32'd0 : 32'(DIV * (2 * l + 1)));
    check({tag, "/sck_edges"}, 32'(sent_q.size()), 32'(l));
    check({tag, "/mosi"}, 32'(assemble(seq, l)), 32'(d & mask_of(l)));
    check({tag, "/ss_ready"}, 32'(viol), 32'd0);
    @(negedge clock);
    check({tag, "/pulse"}, 32'(out_valid), 32'd0);
    check({tag, "/hold"}, 32'(out_data), 32'(rd));
  endtask

  typedef struct {
    logic [15:0] d;
    logic [4:0]  len;
    logic [7:0]  m;
    int          md;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n, cnt, cyc, nresp, high, v0, v1;
    logic [15:0] r0, r1;

    tbl[0] = '{16'hA55A, 5'd16, 8'h01, 0, 16'hA55A};
`ifdef SPI_MASTER_LSB_FIRST_EN
    tbl[1] = '{16'h2D00, 5'd16, 8'h01, 1, 16'h0000};
`else
    tbl[1] = '{16'h2D00, 5'd16, 8'h01, 1, 16'h00B4};
`endif
    tbl[2] = '{16'h1234, 5'd0,  8'h04, 0, 16'h0000};
    tbl[3] = '{16'hFFFF, 5'd20, 8'h01, 0, 16'hFFFF};
    tbl[4] = '{16'h0081, 5'd8,  8'h02, 0, 16'h0081};
    tbl[5] = '{16'h00F3, 5'd5,  8'h10, 0, 16'h0013};
    tbl[6] = '{16'hBEEF, 5'd1,  8'h01, 0, 16'h0001};

    // Reset values
    repeat (3) @(negedge clock);
    check("reset/ss", 32'(ss), 32'hFF);
    check("reset/sck", 32'(sck), 32'd0);
    check("reset/mosi", 32'(mosi), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/out_data", 32'(out_data), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_cmd(tbl[i].d, int'(tbl[i].len), tbl[i].m, tbl[i].md, 1'b1, tbl[i].exp,
              $sformatf("tbl%0d", i));

    // Reset during HIGH of bit 5
    @(negedge clock);
    mode = 0; sent_q.delete();
    in_valid = 1'b1; in_data = 16'hFFFF; in_len = 5'd16; in_ss = 8'h01;
    @(posedge clock);
    #1 in_valid = 1'b0;
    n = 0;
    while (sent_q.size() < 6 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("rst/reach_bit5", 32'(sent_q.size()), 32'd6);
    check("rst/sck_high", 32'(sck), 32'd1);
    reset = 1'b1;
    #1;
    check("rst/ss", 32'(ss), 32'hFF);
    check("rst/sck", 32'(sck), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/out_data", 32'(out_data), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    repeat (300) begin
      @(negedge clock);
      if (out_valid === 1'b1) cnt++;
    end
    check("rst/no_valid", 32'(cnt), 32'd0);
    run_cmd(16'h5A3C, 12, 8'h01, 0, 1'b1, 16'h0A3C, "rst/after");

    // Back-to-back with in_valid held
    @(negedge clock);
    mode = 0; sent_q.delete();
    in_valid = 1'b1; in_data = 16'h0081; in_len = 5'd8; in_ss = 8'h01;
    @(posedge clock);
    cyc = 0; nresp = 0; high = 0; v0 = 0; v1 = 0; r0 = '0; r1 = '0;
    while (nresp < 2 && cyc < 600) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) in_data = 16'h007E;
      if (out_valid === 1'b1) begin
        if (nresp == 0) begin r0 = out_data; v0 = cyc; end
        else begin r1 = out_data; v1 = cyc; end
        nresp++;
      end
      if (nresp < 2 && ss === 8'hFF) high++;
      if (nresp == 1 && busy === 1'b1) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b/count", 32'(nresp), 32'd2);
    check("b2b/first", 32'(r0), 32'h0081);
    check("b2b/second", 32'(r1), 32'h007E);
    check("b2b/ss_gap", 32'(high), 32'd1);
    check("b2b/first_lat", 32'(v0), 32'(DIV * 17 + 1));
    check("b2b/spacing", 32'(v1 - v0), 32'(DIV * 17 + 1));
    check("b2b/first_mosi", 32'((sent_q.size() > 0) ? sent_q[0] : 1'bx),
          32'(sent_bit(16'h0081, 8, 0)));

    // Randomized commands against the reference model
    for (int i = 0; i < 20; i++) begin
      int md, len;
      logic [15:0] d;
      logic [7:0] m;
      md  = 2 * int'($urandom_range(0, 1));
      len = int'($urandom_range(0, 20));
      d   = 16'($urandom);
      m   = 8'($urandom_range(1, 255)) | 8'h01;
      run_cmd(d, len, m, md, 1'b0, 16'h0000, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
